// File: rtl/motor_pkg.sv
// Shared types and constants for the ADC sampling front end of the motor controller.
// Holds the SPI FSM state encoding and the MCP3008 frame geometry.
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } adc_state_t;

    localparam int ADC_FRAME_CYC  = 17;
    localparam int ADC_DATA_FIRST = 8;
    localparam int ADC_BITS       = 10;

    typedef logic [ADC_BITS-1:0] adc_word_t;

    // Command bit presented on DIN during SCLK cycle `cyc` (1-based): start, SGL, D2..D0.
    function automatic logic cmd_bit(input int unsigned cyc, input logic [2:0] ch);
        case (cyc)
            1, 2:    return 1'b1;
            3:       return ch[2];
            4:       return ch[1];
            5:       return ch[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/throttle_map.sv
// Power-of-two moving average over raw ADC samples, followed by a saturated linear
// map to the throttle range. Two register stages: ring/sum update, then map.
module throttle_map
    import motor_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int THR_LO   = 280,
    parameter int THR_HI   = 780,
    parameter int GAIN     = 2,
    parameter int THR_MAX  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] sample,
    input  logic       sample_valid,
    output logic [9:0] throttle,
    output logic       throttle_valid
);

    localparam int N     = 1 << AVG_LOG2;
    localparam int SUM_W = ADC_BITS + AVG_LOG2;
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [11:0] LO_12   = 12'(THR_LO);
    localparam logic [11:0] HI_12   = 12'(THR_HI);
    localparam logic [11:0] GAIN_12 = 12'(GAIN);
    localparam logic [11:0] MAX_12  = 12'(THR_MAX);

    adc_word_t        ring_q [N];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             filled_q, filled_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             sum_vld_q, sum_vld_d;
    logic [9:0]       throttle_q, throttle_d;
    logic             thr_vld_q, thr_vld_d;
    logic [11:0]      avg, span;

    // NOTE: the ring holds data only; the filled flag decides whether its contents are
    // meaningful, so the storage itself needs no reset and stays a plain RAM.
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            for (int i = 0; i < N; i++) begin
                if (!filled_q || PTR_W'(i) == ptr_q) begin
                    ring_q[i] <= sample;
                end
            end
        end
    end

    // NOTE: every signal written here gets its default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        ptr_d      = ptr_q;
        filled_d   = filled_q;
        sum_d      = sum_q;
        sum_vld_d  = sample_valid;
        throttle_d = throttle_q;
        thr_vld_d  = sum_vld_q;

        if (sample_valid) begin
            if (!filled_q) begin
                sum_d    = SUM_W'(sample) << AVG_LOG2;
                filled_d = 1'b1;
                ptr_d    = '0;
            end else begin
                sum_d = sum_q - SUM_W'(ring_q[ptr_q]) + SUM_W'(sample);
                ptr_d = (ptr_q == PTR_W'(N - 1)) ? '0 : ptr_q + 1'b1;
            end
        end

        avg  = 12'(sum_q >> AVG_LOG2);
        span = (avg - LO_12) * GAIN_12;
        if (sum_vld_q) begin
            if (avg <= LO_12) begin
                throttle_d = '0;
            end else if (avg >= HI_12) begin
                throttle_d = MAX_12[9:0];
            end else begin
                throttle_d = (span > MAX_12) ? MAX_12[9:0] : span[9:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            filled_q   <= 1'b0;
            sum_q      <= '0;
            sum_vld_q  <= 1'b0;
            throttle_q <= '0;
            thr_vld_q  <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            filled_q   <= filled_d;
            sum_q      <= sum_d;
            sum_vld_q  <= sum_vld_d;
            throttle_q <= throttle_d;
            thr_vld_q  <= thr_vld_d;
        end
    end

    assign throttle       = throttle_q;
    assign throttle_valid = thr_vld_q;

endmodule

// File: rtl/adc_throttle_sampler.sv
// SPI master running continuous single-ended MCP3008 conversions on one channel,
// publishing each raw result and a filtered, saturated throttle command.
module adc_throttle_sampler
    import motor_pkg::*;
#(
    parameter int CLK_DIV  = 675,
    parameter int CHANNEL  = 4,
    parameter int CS_IDLE  = 4,
    parameter int AVG_LOG2 = 2,
    parameter int THR_LO   = 280,
    parameter int THR_HI   = 780,
    parameter int GAIN     = 2,
    parameter int THR_MAX  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic       adc_din,
    input  logic       adc_dout,
    output logic [9:0] raw,
    output logic       raw_valid,
    output logic [9:0] throttle,
    output logic       throttle_valid
);

    localparam int         DIV_W = $clog2(CLK_DIV);
    localparam int         HC_W  = $clog2(2 * CS_IDLE + 2 * ADC_FRAME_CYC);
    localparam logic [2:0] CH    = 3'(CHANNEL);

    adc_state_t       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [HC_W-1:0]  hc_q, hc_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             din_q, din_d;
    logic             dout_s1_q, dout_s2_q;
    logic [1:0]       rise_q, rise_d;
    adc_word_t        shift_q, shift_d;
    adc_word_t        raw_q, raw_d;
    logic             raw_valid_q, raw_valid_d;
    logic             running, tick;

    always_comb begin
        state_d     = state_q;
        hc_d        = hc_q;
        din_d       = din_q;
        rise_d      = {rise_q[0], 1'b0};
        shift_d     = shift_q;
        raw_d       = raw_q;
        raw_valid_d = 1'b0;

        running = !(state_q == IDLE && !enable);
        tick    = running && (div_q == '0);

        if (!running || tick || state_q == DONE) begin
            div_d = DIV_W'(CLK_DIV - 1);
        end else begin
            div_d = div_q - 1'b1;
        end

        // Every rising edge shifts in; after 17 edges only B9..B0 remain in the register.
        if (rise_q[1]) begin
            shift_d = {shift_q[ADC_BITS-2:0], dout_s2_q};
        end

        case (state_q)
            IDLE: begin
                if (!enable) begin
                    hc_d = '0;
                end else if (tick) begin
                    if (hc_q == HC_W'(2 * CS_IDLE - 1)) begin
                        state_d = SETUP;
                        hc_d    = '0;
                        din_d   = 1'b1;
                    end else begin
                        hc_d = hc_q + 1'b1;
                    end
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d   = SHIFT;
                    hc_d      = '0;
                    rise_d[0] = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (hc_q == HC_W'(2 * ADC_FRAME_CYC - 1)) begin
                        state_d = DONE;
                        din_d   = 1'b0;
                    end else begin
                        hc_d = hc_q + 1'b1;
                        if (hc_q[0]) begin
                            rise_d[0] = 1'b1;
                        end else begin
                            // SCLK is falling: present the bit for the next cycle.
                            din_d = cmd_bit(32'(hc_q >> 1) + 2, CH);
                        end
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                hc_d        = '0;
                raw_d       = shift_q;
                raw_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        cs_n_d = (state_d == IDLE) || (state_d == DONE);
        sclk_d = (state_d == SHIFT) && !hc_d[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= DIV_W'(CLK_DIV - 1);
            hc_q        <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            din_q       <= 1'b0;
            dout_s1_q   <= 1'b0;
            dout_s2_q   <= 1'b0;
            rise_q      <= '0;
            shift_q     <= '0;
            raw_q       <= '0;
            raw_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            hc_q        <= hc_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            din_q       <= din_d;
            dout_s1_q   <= adc_dout;
            dout_s2_q   <= dout_s1_q;
            rise_q      <= rise_d;
            shift_q     <= shift_d;
            raw_q       <= raw_d;
            raw_valid_q <= raw_valid_d;
        end
    end

    throttle_map #(
        .AVG_LOG2 (AVG_LOG2),
        .THR_LO   (THR_LO),
        .THR_HI   (THR_HI),
        .GAIN     (GAIN),
        .THR_MAX  (THR_MAX)
    ) u_map (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample         (raw_q),
        .sample_valid   (raw_valid_q),
        .throttle       (throttle),
        .throttle_valid (throttle_valid)
    );

    assign adc_cs_n  = cs_n_q;
    assign adc_sclk  = sclk_q;
    assign adc_din   = din_q;
    assign raw       = raw_q;
    assign raw_valid = raw_valid_q;

endmodule
